data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side responder for the core's data-memory request interface (memory_read/memory_write, byte address, write data, 4-bit byte mask).
- Replaces the always-ready single-cycle data memory with a wait-stated, word-organised SRAM model.
- Returns one-cycle completion pulses; write_done drives the control unit's write_done input, which holds pc_stall until completion.
- Enables multi-cycle memory timing ahead of cache/bus work.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- ADDR_BITS, 10, word-index width; must equal log2(DEPTH_WORDS).
- WAIT_CYCLES, 2, wait states between request capture and completion; legal range 0..15.

Ports:
- clk  input  1  Clock; all state updates on rising edge.
- reset  input  1  Asynchronous, active-low reset.
- memory_read  input  1  Read request level from control unit.
- memory_write  input  1  Write request level from control unit.
- address  input  32  Byte address from ALU result; bits [1:0] ignored.
- write_data  input  32  Lane-aligned store data from byte enable logic.
- write_mask  input  4  Byte-lane enables; bit n selects write_data[8n+7:8n].
- read_data  output  32  Registered full word from the last completed read.
- read_done  output  1  One-cycle pulse: read complete; read_data valid this cycle and held afterwards.
- write_done  output  1  One-cycle pulse: write committed.
- busy  output  1  High in WAIT and RESP states.
- access_fault  output  1  One-cycle pulse, coincident with done: out-of-range address or illegal request.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - read_data=0; read_done, write_done, busy, access_fault = 0.
  - Wait counter = 0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When memory_read or memory_write is 1, capture address, write_data, write_mask and request type; clear the counter.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - Inputs are not sampled in any other state.
- WAIT:
  - Counter increments every cycle.
  - When counter == WAIT_CYCLES-1, perform the access at the clock edge and go to RESP.
- Access with WAIT_CYCLES=0: performed on the IDLE capture edge.
- RESP (exactly one cycle):
  - Assert write_done or read_done matching the captured type.
  - Assert access_fault if flagged; then return to IDLE.
- Latency: request seen in IDLE at cycle N gives the done pulse in cycle N+1+WAIT_CYCLES.
- Next request: the earliest next capture is the IDLE cycle after RESP. Back-to-back instructions therefore cost WAIT_CYCLES+2 cycles each.
- Request stability: the core holds the request stable until done. The responder relies only on captured values; input changes after capture are ignored.
- Write: for each set mask bit, that byte of word captured_address[ADDR_BITS+1:2] takes the corresponding write_data byte; other bytes are unchanged. Mask 0000 still completes with write_done and writes nothing.
- Read: read_data takes the full stored word; lane extraction stays in byte enable logic.
- Out-of-range (captured_address[31:ADDR_BITS+2] != 0):
  - Writes: no array update.
  - Reads: read_data=0.
  - Done and access_fault both pulse.
- Both memory_read and memory_write high in IDLE:
  - Treated as an illegal request: no access, read_data unchanged.
  - write_done and access_fault pulse in RESP.
- Reset mid-operation (WAIT or RESP): pending access is dropped (no partial write), no done pulse, return to IDLE.
- busy equals (state != IDLE); it is purely registered-state-derived.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.

Test Plan:
- WAIT_CYCLES=2, store 0xABADBABE mask 1111 at 0x100, then load 0x100:
  - write_done 3 cycles after capture cycle.
  - read_done 3 cycles after its capture, read_data=0xABADBABE.
- Partial write: word 0x104=0x11223344; store 0x0000AA00 with mask 0010 → read returns 0x1122AA44.
- Back-to-back stores held continuously (0x0,0x4,0x8), WAIT_CYCLES=2 → write_done pulses exactly 4 cycles apart, all three words correct, busy low for exactly one cycle between them.
- Load 0x00001000 (DEPTH_WORDS=1024) → read_done+access_fault same cycle, read_data=0; store to 0x00001000 leaves word 0 unchanged.
- reset=0 during WAIT of a store 0xDEADBEEF to 0x20 (previously 0x12345678) → no write_done, busy=0 immediately, later read of 0x20 returns 0x12345678.
- WAIT_CYCLES=0 build, load after store to 0x40 → each done one cycle after capture; read_data matches; read and write both high → write_done+access_fault, memory unchanged.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the core (master) and the memory responder (slave).
// The request is a level the core holds stable until it sees the matching done pulse.
interface data_memory_responder_if;
   logic        memory_read;
   logic        memory_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  write_mask;
   logic [31:0] read_data;
   logic        read_done;
   logic        write_done;
   logic        busy;
   logic        access_fault;

   modport master (
      output memory_read, memory_write, address, write_data, write_mask,
      input  read_data, read_done, write_done, busy, access_fault
   );

   modport slave (
      input  memory_read, memory_write, address, write_data, write_mask,
      output read_data, read_done, write_done, busy, access_fault
   );
endinterface

// File: rtl/data_memory_responder.sv
// Wait-stated, word-organised SRAM responder: done pulses WAIT_CYCLES+1 cycles after capture.
// Inputs are sampled only in IDLE, so the core's held request acts as its own backpressure.
module data_memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   data_memory_responder_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int         LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0] LAST_CNT = 4'(LAST_I);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  mask_q, mask_d;
   logic        wr_q, wr_d;
   logic        ill_q, ill_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdone_q, rdone_d;
   logic        wdone_q, wdone_d;
   logic        fault_q, fault_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic                 req;
   logic [31:0]          acc_addr;
   logic [31:0]          acc_wdata;
   logic [3:0]           acc_mask;
   logic                 acc_wr;
   logic                 acc_ill;
   logic                 acc_oor;
   logic [ADDR_BITS-1:0] acc_idx;
   logic                 do_access;
   logic                 mem_we;
   logic                 unused_addr_bits;

   assign req = bus.memory_read | bus.memory_write;

   // With zero wait states the access happens on the capture edge, so it must use the live inputs.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_addr  = bus.address;
         acc_wdata = bus.write_data;
         acc_mask  = bus.write_mask;
         acc_wr    = bus.memory_write;
         acc_ill   = bus.memory_read & bus.memory_write;
      end else begin
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_mask  = mask_q;
         acc_wr    = wr_q;
         acc_ill   = ill_q;
      end
   end

   assign acc_oor          = (acc_addr >> (ADDR_BITS + 2)) != 32'd0;
   assign acc_idx          = acc_addr[ADDR_BITS+1:2];
   assign unused_addr_bits = ^acc_addr[1:0];

   assign do_access = ((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == LAST_CNT));
   assign mem_we    = do_access & acc_wr & ~acc_ill & ~acc_oor & reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      wr_d    = wr_q;
      ill_d   = ill_q;
      rdata_d = rdata_q;
      rdone_d = 1'b0;
      wdone_d = 1'b0;
      fault_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = bus.address;
               wdata_d = bus.write_data;
               mask_d  = bus.write_mask;
               wr_d    = bus.memory_write;
               ill_d   = bus.memory_read & bus.memory_write;
               cnt_d   = 4'd0;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Illegal read+write requests report as writes, so read_data is never touched by them.
      if (do_access) begin
         wdone_d = acc_wr;
         rdone_d = ~acc_wr;
         fault_d = acc_oor | acc_ill;
         if (!acc_wr) rdata_d = acc_oor ? 32'd0 : mem[acc_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         mask_q  <= 4'd0;
         wr_q    <= 1'b0;
         ill_q   <= 1'b0;
         rdata_q <= 32'd0;
         rdone_q <= 1'b0;
         wdone_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         wr_q    <= wr_d;
         ill_q   <= ill_d;
         rdata_q <= rdata_d;
         rdone_q <= rdone_d;
         wdone_q <= wdone_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_mask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   assign bus.read_data    = rdata_q;
   assign bus.read_done    = rdone_q;
   assign bus.write_done   = wdone_q;
   assign bus.access_fault = fault_q;
   assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a 2-wait-state and a zero-wait-state instance side by side.
module tb_data_memory_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2_n;
   logic rst0_n;

   data_memory_responder_if if2 ();
   data_memory_responder_if if0 ();

   data_memory_responder #(.DEPTH_WORDS(1024), .ADDR_BITS(10), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .reset(rst2_n), .bus(if2)
   );
   data_memory_responder #(.DEPTH_WORDS(1024), .ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(rst0_n), .bus(if0)
   );

   typedef struct {
      int          d;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  m;
      logic [31:0] erd;
      logic        ewd;
      logic        ef;
   } vec_t;

   typedef struct {
      logic        rdn;
      logic        wdn;
      logic        flt;
      logic [31:0] rdat;
      int          lat;
   } exp_t;

   vec_t tv [21];
   exp_t sb [$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   txn_id  = 0;

   logic [31:0] bb_a [3];
   logic [31:0] bb_d [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
      if (d == 0) begin
         if0.memory_read = rd; if0.memory_write = wr; if0.address = a;
         if0.write_data = wd; if0.write_mask = m;
      end else begin
         if2.memory_read = rd; if2.memory_write = wr; if2.address = a;
         if2.write_data = wd; if2.write_mask = m;
      end
   endtask

   task automatic sample(input int d, output logic rdn, output logic wdn, output logic flt,
                         output logic bsy, output logic [31:0] rdat);
      if (d == 0) begin
         rdn = if0.read_done; wdn = if0.write_done; flt = if0.access_fault;
         bsy = if0.busy; rdat = if0.read_data;
      end else begin
         rdn = if2.read_done; wdn = if2.write_done; flt = if2.access_fault;
         bsy = if2.busy; rdat = if2.read_data;
      end
   endtask

   // One request held until its done pulse; expectation queued on drive, popped on completion.
   task automatic txn(input int d, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] m, input logic [31:0] erd,
                      input logic ewd, input logic ef);
      exp_t        e;
      int          lat;
      bit          seen;
      logic        rdn, wdn, flt, bsy;
      logic [31:0] rdat;
      string       tag;
      tag   = $sformatf("txn%0d", txn_id);
      txn_id++;
      e.rdn = ~ewd;
      e.wdn = ewd;
      e.flt = ef;
      e.rdat = erd;
      e.lat = (d == 0) ? 1 : 3;
      sb.push_back(e);
      @(negedge clk);
      drive(d, rd, wr, a, wd, m);
      seen = 1'b0;
      lat  = 0;
      rdn = 1'b0; wdn = 1'b0; flt = 1'b0; bsy = 1'b0; rdat = 32'd0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         sample(d, rdn, wdn, flt, bsy, rdat);
         if (rdn | wdn) seen = 1'b1;
      end
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      e = sb.pop_front();
      if (!seen) begin
         chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_latency"}, lat, e.lat);
         chk({tag, "_read_done"}, {31'd0, rdn}, {31'd0, e.rdn});
         chk({tag, "_write_done"}, {31'd0, wdn}, {31'd0, e.wdn});
         chk({tag, "_access_fault"}, {31'd0, flt}, {31'd0, e.flt});
         chk({tag, "_read_data"}, rdat, e.rdat);
         chk({tag, "_busy_in_resp"}, {31'd0, bsy}, 32'd1);
      end
   endtask

   initial begin
      logic        rdn, wdn, flt, bsy;
      logic [31:0] rdat;
      int          idx, last, busy_low, pulses;

      tv[0]  = '{2, 1'b0, 1'b1, 32'h0000_0100, 32'hABAD_BABE, 4'hF, 32'h0000_0000, 1'b1, 1'b0};
      tv[1]  = '{2, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hABAD_BABE, 1'b0, 1'b0};
      tv[2]  = '{2, 1'b0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'hF, 32'hABAD_BABE, 1'b1, 1'b0};
      tv[3]  = '{2, 1'b0, 1'b1, 32'h0000_0104, 32'h0000_AA00, 4'h2, 32'hABAD_BABE, 1'b1, 1'b0};
      tv[4]  = '{2, 1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'h1122_AA44, 1'b0, 1'b0};
      tv[5]  = '{2, 1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h1122_AA44, 1'b1, 1'b0};
      tv[6]  = '{2, 1'b0, 1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 32'h1122_AA44, 1'b1, 1'b0};
      tv[7]  = '{2, 1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'h1122_AA44, 1'b0, 1'b0};
      tv[8]  = '{2, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 1'b1};
      tv[9]  = '{2, 1'b0, 1'b1, 32'h0000_1000, 32'h9999_9999, 4'hF, 32'h0000_0000, 1'b1, 1'b1};
      tv[10] = '{2, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 1'b0};
      tv[11] = '{2, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b1};
      tv[12] = '{2, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 1'b0};
      tv[13] = '{2, 1'b1, 1'b0, 32'h0000_0103, 32'h0,         4'h0, 32'hABAD_BABE, 1'b0, 1'b0};
      tv[14] = '{2, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 32'hABAD_BABE, 1'b1, 1'b0};
      tv[15] = '{2, 1'b1, 1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 32'h0102_0304, 1'b0, 1'b0};
      tv[16] = '{2, 1'b1, 1'b0, 32'h8000_0100, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 1'b1};
      tv[17] = '{0, 1'b0, 1'b1, 32'h0000_0040, 32'h5A5A_A5A5, 4'hF, 32'h0000_0000, 1'b1, 1'b0};
      tv[18] = '{0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h5A5A_A5A5, 1'b0, 1'b0};
      tv[19] = '{0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, 32'h5A5A_A5A5, 1'b1, 1'b1};
      tv[20] = '{0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h5A5A_A5A5, 1'b0, 1'b0};

      bb_a[0] = 32'h0; bb_a[1] = 32'h4; bb_a[2] = 32'h8;
      bb_d[0] = 32'h0BAD_0000; bb_d[1] = 32'h0BAD_0001; bb_d[2] = 32'h0BAD_0002;

      rst2_n = 1'b0;
      rst0_n = 1'b0;
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);
      for (int d = 0; d <= 2; d += 2) begin
         sample(d, rdn, wdn, flt, bsy, rdat);
         chk($sformatf("reset_d%0d_read_data", d), rdat, 32'd0);
         chk($sformatf("reset_d%0d_read_done", d), {31'd0, rdn}, 32'd0);
         chk($sformatf("reset_d%0d_write_done", d), {31'd0, wdn}, 32'd0);
         chk($sformatf("reset_d%0d_busy", d), {31'd0, bsy}, 32'd0);
         chk($sformatf("reset_d%0d_fault", d), {31'd0, flt}, 32'd0);
      end
      rst2_n = 1'b1;
      rst0_n = 1'b1;

      for (int i = 0; i < 21; i++)
         txn(tv[i].d, tv[i].rd, tv[i].wr, tv[i].a, tv[i].wd, tv[i].m, tv[i].erd, tv[i].ewd, tv[i].ef);

      // Three stores held continuously: pulses 4 cycles apart with a single idle cycle between.
      @(negedge clk);
      drive(2, 1'b0, 1'b1, bb_a[0], bb_d[0], 4'hF);
      idx = 0; last = 0; busy_low = 0;
      for (int c = 0; c < 40 && idx < 3; c++) begin
         @(negedge clk);
         sample(2, rdn, wdn, flt, bsy, rdat);
         if (!bsy) busy_low++;
         if (wdn) begin
            if (idx > 0) begin
               chk($sformatf("b2b_gap%0d", idx), c - last, 32'd4);
               chk($sformatf("b2b_busy_low%0d", idx), busy_low, 32'd1);
            end
            last = c;
            busy_low = 0;
            idx++;
            if (idx < 3) drive(2, 1'b0, 1'b1, bb_a[idx], bb_d[idx], 4'hF);
            else         drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
         end
      end
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("b2b_pulse_count", idx, 32'd3);
      txn(2, 1'b1, 1'b0, bb_a[0], 32'd0, 4'd0, bb_d[0], 1'b0, 1'b0);
      txn(2, 1'b1, 1'b0, bb_a[1], 32'd0, 4'd0, bb_d[1], 1'b0, 1'b0);
      txn(2, 1'b1, 1'b0, bb_a[2], 32'd0, 4'd0, bb_d[2], 1'b0, 1'b0);

      // Reset during the wait of a store must drop it entirely.
      txn(2, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, bb_d[2], 1'b1, 1'b0);
      @(negedge clk);
      drive(2, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      sample(2, rdn, wdn, flt, bsy, rdat);
      chk("midrst_busy_before", {31'd0, bsy}, 32'd1);
      rst2_n = 1'b0;
      #1;
      sample(2, rdn, wdn, flt, bsy, rdat);
      chk("midrst_busy_after", {31'd0, bsy}, 32'd0);
      chk("midrst_read_data", rdat, 32'd0);
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      rst2_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         sample(2, rdn, wdn, flt, bsy, rdat);
         if (wdn | rdn) pulses++;
      end
      chk("midrst_no_done", pulses, 32'd0);
      txn(2, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0, 32'h1234_5678, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
